// File: rtl/step_sequencer_ctrl_if.sv
// Handshake bundle between the step sequencer controller and its stepped datapath.
// The slave modport is the controller's view; master is the driving side's view.
interface step_sequencer_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic         pause;
  logic         mode;
  logic [W-1:0] seed;
  logic [3:0]   steps;
  logic [W-1:0] target;
  logic [W-1:0] q;
  logic         ce;
  logic         load;
  logic [W-1:0] load_val;
  logic         busy;
  logic         done;
  logic         hit;
  logic [4:0]   count;

  modport slave (
    input  start, pause, mode, seed, steps, target, q,
    output ce, load, load_val, busy, done, hit, count
  );

  modport master (
    output start, pause, mode, seed, steps, target, q,
    input  ce, load, load_val, busy, done, hit, count
  );
endinterface

// File: rtl/step_sequencer_ctrl.sv
// Step sequencer controller: loads a seed into an external stepped register, then
// enables stepping until a step budget runs out or (MODE=1) the register hits TARGET.
module step_sequencer_ctrl #(
  parameter int W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  step_sequencer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e       state_q;
  logic [W-1:0] seed_q;
  logic [W-1:0] target_q;
  logic [3:0]   steps_q;
  logic         mode_q;
  logic [4:0]   count_q;
  logic         hit_q;

  logic [4:0]   budget_s;
  logic         hit_now_s;
  logic         budget_end_s;
  logic         ce_s;

  // Run-cycle decisions: target match outranks budget exhaustion, which outranks pause.
  always_comb begin
    budget_s     = {1'b0, steps_q};
    hit_now_s    = 1'b0;
    budget_end_s = 1'b0;
    ce_s         = 1'b0;
    if (mode_q && (steps_q == 4'd0)) begin
      budget_s = 5'd16;
    end else begin
      budget_s = {1'b0, steps_q};
    end
    if (state_q == S_RUN) begin
      hit_now_s    = mode_q && (bus.q == target_q);
      budget_end_s = (count_q == budget_s);
      ce_s         = !hit_now_s && !budget_end_s && !bus.pause;
    end else begin
      hit_now_s    = 1'b0;
      budget_end_s = 1'b0;
      ce_s         = 1'b0;
    end
  end

  assign bus.ce       = ce_s;
  assign bus.load     = (state_q == S_LOAD);
  assign bus.busy     = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.load_val = seed_q;
  assign bus.hit      = hit_q;
  assign bus.count    = count_q;

  // Sequencer state, captured run parameters and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      seed_q   <= '0;
      target_q <= '0;
      steps_q  <= 4'd0;
      mode_q   <= 1'b0;
      count_q  <= 5'd0;
      hit_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            seed_q   <= bus.seed;
            target_q <= bus.target;
            steps_q  <= bus.steps;
            mode_q   <= bus.mode;
            count_q  <= 5'd0;
            hit_q    <= 1'b0;
            state_q  <= S_LOAD;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_LOAD: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (hit_now_s) begin
            hit_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (budget_end_s) begin
            state_q <= S_DONE;
          end else if (ce_s) begin
            count_q <= count_q + 5'd1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Scoreboard bench for step_sequencer_ctrl: the stimulus side predicts each run's
// outcome from the sequencing rules; an independent monitor checks every DONE.
module tb_step_sequencer_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_sequencer_ctrl_if #(.W(W)) bus ();
  step_sequencer_ctrl #(.W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Stepped datapath: loads the seed, advances by 2 (mod 16) on each CE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.q <= '0;
    else if (bus.load) bus.q <= bus.load_val;
    else if (bus.ce) bus.q <= bus.q + 4'd2;
  end

  typedef struct {
    int   done_cyc;
    int   n;
    bit   hit;
    int   seed;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: number of steps taken and whether the target was reached.
  function automatic void ref_run(input bit mode, input int seed, input int steps,
                                  input int target, output int n, output bit hit);
    int b;
    b   = (mode && steps == 0) ? 16 : steps;
    n   = b;
    hit = 1'b0;
    if (mode) begin
      for (int k = 0; k <= b; k++) begin
        if (((seed + 2 * k) % 16) == target) begin
          n   = k;
          hit = 1'b1;
          break;
        end
      end
    end
  endfunction

  // Monitor
  int   ce_cnt = 0;
  int   load_cnt = 0;
  int   load_val_seen = 0;
  bit   hold_pend = 1'b0;
  exp_t hold_e;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      ce_cnt    = 0;
      load_cnt  = 0;
      hold_pend = 1'b0;
    end else begin
      check("load_ce_overlap", int'(bus.load & bus.ce), 0);
      check("ce_outside_busy", int'(bus.ce & ~bus.busy), 0);
      if (hold_pend) begin
        check("hold_count", int'(bus.count), hold_e.n);
        check("hold_hit", int'(bus.hit), int'(hold_e.hit));
        hold_pend = 1'b0;
      end
      if (bus.load) begin
        load_cnt++;
        load_val_seen = int'(bus.load_val);
        ce_cnt = 0;
      end
      if (bus.ce) ce_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("done_without_run", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("ce_pulses", ce_cnt, e.n);
          check("count", int'(bus.count), e.n);
          check("hit", int'(bus.hit), int'(e.hit));
          check("load_val", load_val_seen, e.seed);
          check("load_pulses", load_cnt, 1);
          check("done_ce", int'(bus.ce), 0);
          hold_e    = e;
          hold_pend = 1'b1;
        end
        load_cnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ce"}, int'(bus.ce), 0);
    check({tag, "_load"}, int'(bus.load), 0);
    check({tag, "_load_val"}, int'(bus.load_val), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_hit"}, int'(bus.hit), 0);
    check({tag, "_count"}, int'(bus.count), 0);
  endtask

  task automatic run(input bit mode, input int seed, input int steps, input int target,
                     input bit do_pause, input int k_sel, input int p_len, input bit noise);
    int  n;
    bit  hit;
    int  t0;
    int  k;
    bit  pz;
    exp_t x;
    ref_run(mode, seed, steps, target, n, hit);
    pz = do_pause && (n > 0);
    k  = (n > 0) ? (k_sel % n) : 0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.mode   = mode;
    bus.seed   = 4'(seed);
    bus.steps  = 4'(steps);
    bus.target = 4'(target);
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    x.done_cyc = t0 + 2 + n + (pz ? p_len : 0);
    x.n    = n;
    x.hit  = hit;
    x.seed = seed;
    sb.push_back(x);
    if (noise) begin
      bus.mode   = 1'($urandom);
      bus.seed   = 4'($urandom);
      bus.steps  = 4'($urandom);
      bus.target = 4'($urandom);
    end
    fork
      begin
        if (noise) begin
          bus.start = 1'b1;
          @(posedge clk); #1;
          @(posedge clk); #1;
          bus.start = 1'b0;
        end
      end
      begin
        if (pz) begin
          repeat (1 + k) @(posedge clk);
          #1 bus.pause = 1'b1;
          #3;
          check("pause_count_held", int'(bus.count), k);
          check("pause_ce", int'(bus.ce), 0);
          repeat (p_len) @(posedge clk);
          #1 bus.pause = 1'b0;
        end
      end
    join
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("run_timeout", sb.size(), 0);
    sb.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.mode   = 1'b0;
    bus.seed   = '0;
    bus.steps  = 4'd0;
    bus.target = '0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(1'b0, 5, 3, 0, 1'b0, 0, 0, 1'b0);
    run(1'b0, 7, 4, 0, 1'b1, 2, 2, 1'b0);
    run(1'b1, 9, 5, 9, 1'b0, 0, 0, 1'b0);
    run(1'b0, 3, 0, 0, 1'b0, 0, 0, 1'b0);
    run(1'b1, 2, 0, 7, 1'b0, 0, 0, 1'b0);
    run(1'b1, 1, 0, 5, 1'b0, 0, 0, 1'b1);
    run(1'b0, 6, 15, 0, 1'b1, 7, 3, 1'b1);

    // Abort mid-run with reset: no DONE may follow.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 1'b0; bus.seed = 4'd11; bus.steps = 4'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 check("pre_abort_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("idle_after_abort", int'(bus.busy), 0);

    for (int r = 0; r < 40; r++) begin
      run(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 15)),
          int'($urandom_range(1, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
